// File: rtl/sa_pkg.sv
// Shared definitions for the simulated-annealing acceptance path: constants,
// controller state encoding and IEEE-754 single-precision field helpers.
package sa_pkg;

    localparam logic [31:0] FP_ONE    = 32'h3f800000;
    localparam logic [23:0] LFSR_TAPS = 24'hE10000;
    localparam logic [24:0] EFIX_ONE  = 25'h1000000;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        LAUNCH,
        WAIT_LO,
        WAIT_HI,
        DECIDE,
        RESP
    } sa_accept_state_t;

    function automatic logic fp_sign(input logic [31:0] f);
        return f[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] f);
        return f[30:23];
    endfunction

    function automatic logic [22:0] fp_man(input logic [31:0] f);
        return f[22:0];
    endfunction

endpackage

// File: rtl/sa_accept_if.sv
// Request, negexp and decision signals of the acceptance controller.
// slave = controller view, master = upstream/negexp/downstream view.
interface sa_accept_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_delta;
    logic [31:0] req_neg_inv_temp;
    logic [31:0] nx_inp;
    logic        nx_inp_valid;
    logic [31:0] nx_out;
    logic        nx_out_valid;
    logic        dec_valid;
    logic        dec_ready;
    logic        dec_accept;
    logic        dec_fast;

    modport slave (
        input  req_valid, req_delta, req_neg_inv_temp, nx_out, nx_out_valid, dec_ready,
        output req_ready, nx_inp, nx_inp_valid, dec_valid, dec_accept, dec_fast
    );

    modport master (
        output req_valid, req_delta, req_neg_inv_temp, nx_out, nx_out_valid, dec_ready,
        input  req_ready, nx_inp, nx_inp_valid, dec_valid, dec_accept, dec_fast
    );
endinterface

// File: rtl/floating_point_mult.sv
// Single-precision multiplier, one-cycle latency, round-to-nearest-even,
// denormals flushed to zero.
module floating_point_mult
    import sa_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_axis_a_tvalid,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_b_tvalid,
    input  logic [31:0] s_axis_b_tdata,
    output logic        m_axis_result_tvalid,
    output logic [31:0] m_axis_result_tdata
);
    logic        sign;
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb, man;
    logic [47:0] prod, norm;
    logic        round_up;
    logic [24:0] mant_r;
    logic [9:0]  e_sum;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0] res;
    logic        tvalid_q, tvalid_d;
    logic [31:0] result_q, result_d;

    always_comb begin
        sign     = fp_sign(s_axis_a_tdata) ^ fp_sign(s_axis_b_tdata);
        ea       = fp_exp(s_axis_a_tdata);
        eb       = fp_exp(s_axis_b_tdata);
        ma       = fp_man(s_axis_a_tdata);
        mb       = fp_man(s_axis_b_tdata);
        prod     = 48'({1'b1, ma}) * 48'({1'b1, mb});
        norm     = prod[47] ? prod : {prod[46:0], 1'b0};
        round_up = norm[23] & ((|norm[22:0]) | norm[24]);
        mant_r   = {1'b0, norm[47:24]} + {24'd0, round_up};
        // Exponent kept biased by 127 twice so the range tests stay unsigned.
        e_sum    = {2'b0, ea} + {2'b0, eb} + {9'd0, prod[47]} + {9'd0, mant_r[24]};
        man      = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        a_nan    = (ea == 8'hFF) && (ma != 23'd0);
        b_nan    = (eb == 8'hFF) && (mb != 23'd0);
        a_inf    = (ea == 8'hFF) && (ma == 23'd0);
        b_inf    = (eb == 8'hFF) && (mb == 23'd0);
        a_zero   = (ea == 8'h00);
        b_zero   = (eb == 8'h00);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res = 32'h7FC00000;
        end else if (a_inf || b_inf || (e_sum >= 10'd382)) begin
            res = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero || (e_sum <= 10'd127)) begin
            res = {sign, 31'd0};
        end else begin
            res = {sign, 8'(e_sum - 10'd127), man};
        end

        tvalid_d = s_axis_a_tvalid & s_axis_b_tvalid;
        result_d = tvalid_d ? res : result_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tvalid_q <= 1'b0;
            result_q <= 32'd0;
        end else begin
            tvalid_q <= tvalid_d;
            result_q <= result_d;
        end
    end

    assign m_axis_result_tvalid = tvalid_q;
    assign m_axis_result_tdata  = result_q;
endmodule

// File: rtl/sa_lfsr24.sv
// 24-bit Galois LFSR (x^24+x^23+x^22+x^17+1) used as the uniform variate source.
module sa_lfsr24
    import sa_pkg::*;
#(
    parameter logic [23:0] SEED = 24'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [23:0] state
);
    logic [23:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (step) begin
            state_d = {1'b0, state_q[23:1]} ^ (state_q[0] ? LFSR_TAPS : 24'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
endmodule

// File: rtl/sa_accept.sv
// Metropolis acceptance controller: x = delta * (-1/T), e = negexp(x),
// accept when the LFSR variate is below e in Q0.24.
module sa_accept
    import sa_pkg::*;
#(
    parameter logic [23:0] SEED = 24'hACE1
) (
    input  logic           clk,
    input  logic           rst_n,
    sa_accept_if.slave     bus
);
    sa_accept_state_t state_q, state_d;
    logic [31:0] delta_q, delta_d;
    logic [31:0] nit_q, nit_d;
    logic        mul_start_q, mul_start_d;
    logic [31:0] nx_inp_q, nx_inp_d;
    logic        nx_inp_valid_q, nx_inp_valid_d;
    logic [31:0] e_q, e_d;
    logic        dec_valid_q, dec_valid_d;
    logic        dec_accept_q, dec_accept_d;
    logic        dec_fast_q, dec_fast_d;
    logic [23:0] rnd;
    logic        lfsr_step;
    logic        mul_tvalid;
    logic [31:0] mul_tdata;

    function automatic logic [24:0] to_efix(input logic [31:0] f);
        logic [7:0]  ex;
        logic [24:0] r;
        ex = fp_exp(f);
        r  = 25'd0;
        if (fp_sign(f)) begin
            r = 25'd0;
        end else if (ex >= fp_exp(FP_ONE)) begin
            r = EFIX_ONE;
        end else if (ex >= 8'd103) begin
            r = {1'b0, 1'b1, fp_man(f)} >> 5'(8'd126 - ex);
        end
        return r;
    endfunction

    function automatic logic is_nonpos(input logic [31:0] f);
        return fp_sign(f) || (f[30:0] == 31'd0);
    endfunction

    // The variate advances only on the cycle e is captured.
    assign lfsr_step = (state_q == WAIT_HI) && bus.nx_out_valid;

    sa_lfsr24 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .state (rnd)
    );

    floating_point_mult u_mult (
        .aclk                 (clk),
        .aresetn              (rst_n),
        .s_axis_a_tvalid      (mul_start_q),
        .s_axis_a_tdata       (delta_q),
        .s_axis_b_tvalid      (mul_start_q),
        .s_axis_b_tdata       (nit_q),
        .m_axis_result_tvalid (mul_tvalid),
        .m_axis_result_tdata  (mul_tdata)
    );

    always_comb begin
        state_d        = state_q;
        delta_d        = delta_q;
        nit_d          = nit_q;
        mul_start_d    = 1'b0;
        nx_inp_d       = nx_inp_q;
        nx_inp_valid_d = nx_inp_valid_q;
        e_d            = e_q;
        dec_valid_d    = dec_valid_q;
        dec_accept_d   = dec_accept_q;
        dec_fast_d     = dec_fast_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    delta_d = bus.req_delta;
                    nit_d   = bus.req_neg_inv_temp;
                    if (is_nonpos(bus.req_delta)) begin
                        state_d      = RESP;
                        dec_valid_d  = 1'b1;
                        dec_accept_d = 1'b1;
                        dec_fast_d   = 1'b1;
                    end else begin
                        state_d     = MUL;
                        mul_start_d = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mul_tvalid) begin
                    nx_inp_d       = mul_tdata;
                    nx_inp_valid_d = 1'b1;
                    state_d        = LAUNCH;
                end
            end
            // negexp takes the launch on the first cycle it reports idle.
            LAUNCH: begin
                if (bus.nx_out_valid) begin
                    nx_inp_valid_d = 1'b0;
                    state_d        = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.nx_out_valid) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.nx_out_valid) begin
                    e_d     = bus.nx_out;
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                dec_valid_d  = 1'b1;
                dec_accept_d = ({1'b0, rnd} < to_efix(e_q));
                dec_fast_d   = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.dec_ready) begin
                    dec_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            delta_q        <= 32'd0;
            nit_q          <= 32'd0;
            mul_start_q    <= 1'b0;
            nx_inp_q       <= 32'd0;
            nx_inp_valid_q <= 1'b0;
            e_q            <= 32'd0;
            dec_valid_q    <= 1'b0;
            dec_accept_q   <= 1'b0;
            dec_fast_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            delta_q        <= delta_d;
            nit_q          <= nit_d;
            mul_start_q    <= mul_start_d;
            nx_inp_q       <= nx_inp_d;
            nx_inp_valid_q <= nx_inp_valid_d;
            e_q            <= e_d;
            dec_valid_q    <= dec_valid_d;
            dec_accept_q   <= dec_accept_d;
            dec_fast_q     <= dec_fast_d;
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.nx_inp       = nx_inp_q;
    assign bus.nx_inp_valid = nx_inp_valid_q;
    assign bus.dec_valid    = dec_valid_q;
    assign bus.dec_accept   = dec_accept_q;
    assign bus.dec_fast     = dec_fast_q;
endmodule

// File: tb/tb_sa_accept.sv
// Directed bench for sa_accept with a behavioural negexp stub whose result
// is set per transaction.
module tb_sa_accept;
    import sa_pkg::*;

    typedef struct {
        logic [31:0] delta;
        logic [31:0] nit;
        logic [31:0] e;
        logic [31:0] x;
        logic        fast;
        logic [24:0] efix;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_accept_if bus();

    sa_accept #(.SEED(24'hACE1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] lfsr_m;
    logic [31:0] stub_e;
    int          stub_busy;
    int          stub_phase;
    int          stub_cnt;
    int          launch_count;
    vec_t        vecs[12];

    // negexp stub: idle-high, one stale idle cycle after a launch, then busy.
    initial begin : negexp_stub
        bit fire;
        bus.nx_out_valid = 1'b1;
        bus.nx_out       = 32'd0;
        stub_phase       = 0;
        stub_cnt         = 0;
        stub_busy        = 0;
        launch_count     = 0;
        forever begin
            @(negedge clk);
            fire = bus.nx_inp_valid && bus.nx_out_valid;
            @(posedge clk);
            #1;
            case (stub_phase)
                0: begin
                    if (fire) begin
                        launch_count++;
                        stub_phase = 1;
                    end else if (stub_busy > 0) begin
                        bus.nx_out_valid = 1'b0;
                        stub_busy--;
                    end else begin
                        bus.nx_out_valid = 1'b1;
                    end
                end
                1: begin
                    bus.nx_out_valid = 1'b0;
                    stub_cnt = 3;
                    stub_phase = 2;
                end
                default: begin
                    if (stub_cnt > 0) begin
                        stub_cnt--;
                    end else begin
                        bus.nx_out       = stub_e;
                        bus.nx_out_valid = 1'b1;
                        stub_phase       = 0;
                    end
                end
            endcase
        end
    end

    function automatic logic [23:0] lfsr_next(input logic [23:0] s);
        return {1'b0, s[23:1]} ^ (s[0] ? 24'hE10000 : 24'h000000);
    endfunction

    function automatic logic [31:0] fix_to_float(input logic [24:0] t);
        int p;
        int sh;
        logic [23:0] m;
        p = -1;
        if (t[24]) return 32'h3F800000;
        for (int i = 0; i < 24; i++) if (t[i]) p = i;
        if (p < 0) return 32'h0;
        sh = 23 - p;
        m  = t[23:0] << sh;
        return {1'b0, 8'(126 - sh), m[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_step(input logic [24:0] efix, output logic acc);
        lfsr_m = lfsr_next(lfsr_m);
        acc = ({1'b0, lfsr_m} < efix);
    endtask

    task automatic start_req(input logic [31:0] d, input logic [31:0] t, input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_delta = d;
        bus.req_neg_inv_temp = t;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_dec(output bit ok, output int cyc, output bit seen, output logic [31:0] x);
        ok = 0; seen = 0; x = 32'd0; cyc = 1;
        while (cyc < 300) begin
            if (bus.nx_inp_valid) begin
                seen = 1;
                x = bus.nx_inp;
            end
            if (bus.dec_valid) begin
                ok = 1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic finish_dec();
        bus.dec_ready = 1'b1;
        tick();
        bus.dec_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit ok, seen;
        int cyc, lc0;
        logic [31:0] x;
        logic exp_acc;
        stub_e = v.e;
        lc0 = launch_count;
        start_req(v.delta, v.nit, tag);
        wait_dec(ok, cyc, seen, x);
        check({tag, "_done"}, ok, 1'b1);
        if (v.fast) begin
            exp_acc = 1'b1;
            check({tag, "_latency"}, cyc, 1);
            check({tag, "_no_launch"}, seen || (launch_count != lc0), 1'b0);
        end else begin
            model_step(v.efix, exp_acc);
            check({tag, "_x"}, x, v.x);
        end
        check({tag, "_accept"}, bus.dec_accept, exp_acc);
        check({tag, "_fast"}, bus.dec_fast, v.fast);
        finish_dec();
        check({tag, "_lfsr"}, dut.rnd, lfsr_m);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, seen;
        int cyc, n, hold;
        logic [31:0] x, x0;
        logic exp_acc;
        logic [23:0] rn;
        vec_t v;

        bus.req_valid = 1'b0;
        bus.req_delta = 32'd0;
        bus.req_neg_inv_temp = 32'd0;
        bus.dec_ready = 1'b0;
        stub_e = 32'd0;

        //          delta          -1/T           e              x              fast  efix
        vecs[0]  = '{32'hC0000000, 32'hBF800000, 32'h3F800000, 32'h00000000, 1'b1, 25'h0};
        vecs[1]  = '{32'h00000000, 32'hBF800000, 32'h3F800000, 32'h00000000, 1'b1, 25'h0};
        vecs[2]  = '{32'h80000000, 32'hBF800000, 32'h3F800000, 32'h00000000, 1'b1, 25'h0};
        vecs[3]  = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000, 1'b0, 25'h1000000};
        vecs[4]  = '{32'h40000000, 32'hBF000000, 32'hBE000000, 32'hBF800000, 1'b0, 25'h0};
        vecs[5]  = '{32'h3F000000, 32'hBE800000, 32'h33000000, 32'hBE000000, 1'b0, 25'h0};
        vecs[6]  = '{32'h40400000, 32'hC0000000, 32'h7F800000, 32'hC0C00000, 1'b0, 25'h1000000};
        vecs[7]  = '{32'h3FC00000, 32'hBFC00000, 32'h3F000000, 32'hC0100000, 1'b0, 25'h800000};
        vecs[8]  = '{32'h3F800000, 32'hBF000000, 32'h3E800000, 32'hBF000000, 1'b0, 25'h400000};
        vecs[9]  = '{32'h40000000, 32'hBF800000, 32'h3F400000, 32'hC0000000, 1'b0, 25'hC00000};
        vecs[10] = '{32'h3F800000, 32'hBF800000, 32'h33800000, 32'hBF800000, 1'b0, 25'h1};
        vecs[11] = '{32'h3F800000, 32'hBF800000, 32'h7FC00000, 32'hBF800000, 1'b0, 25'h1000000};

        // Reset held for three cycles.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_dec_valid", bus.dec_valid, 1'b0);
        check("rst_nx_inp_valid", bus.nx_inp_valid, 1'b0);
        check("rst_nx_inp", bus.nx_inp, 32'h0);
        check("rst_dec_accept", bus.dec_accept, 1'b0);
        check("rst_lfsr", dut.rnd, 24'hACE1);
        rst_n = 1'b1;
        lfsr_m = 24'hACE1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            $display("vec%0d delta=%h e=%h accept=%0b fast=%0b", i, vecs[i].delta, vecs[i].e,
                     bus.dec_accept, bus.dec_fast);
        end

        // Exact threshold: efix equal to rnd rejects, efix = rnd+1 accepts.
        rn = lfsr_next(lfsr_m);
        v = '{32'h3F800000, 32'hBF800000, fix_to_float({1'b0, rn}), 32'hBF800000, 1'b0, {1'b0, rn}};
        run_vec(v, "thr_eq");
        check("thr_eq_reject", bus.dec_accept, 1'b0);
        rn = lfsr_next(lfsr_m);
        v = '{32'h3F800000, 32'hBF800000, fix_to_float({1'b0, rn} + 25'd1), 32'hBF800000, 1'b0,
              {1'b0, rn} + 25'd1};
        run_vec(v, "thr_gt");
        check("thr_gt_accept", bus.dec_accept, 1'b1);
        $display("threshold rnd=%h done", rn);

        // negexp busy before the launch: request must be held stable.
        stub_e = 32'h3F000000;
        stub_busy = 10;
        start_req(32'h3F800000, 32'hBF800000, "busy");
        n = 0;
        while (!bus.nx_inp_valid && n < 50) begin
            tick();
            n++;
        end
        check("busy_launch_seen", bus.nx_inp_valid, 1'b1);
        x0 = bus.nx_inp;
        hold = 0;
        while (!bus.nx_out_valid && hold < 50) begin
            check("busy_hold_valid", bus.nx_inp_valid, 1'b1);
            check("busy_hold_inp", bus.nx_inp, x0);
            hold++;
            tick();
        end
        check("busy_hold_cycles", hold >= 4, 1'b1);
        check("busy_x", x0, 32'hBF800000);
        wait_dec(ok, cyc, seen, x);
        check("busy_done", ok, 1'b1);
        model_step(25'h800000, exp_acc);
        check("busy_accept", bus.dec_accept, exp_acc);
        finish_dec();
        $display("busy hold=%0d accept=%0b", hold, exp_acc);

        // Downstream stall: decision held while dec_ready is low.
        stub_e = 32'h3F400000;
        start_req(32'h3F800000, 32'hBF800000, "stall");
        wait_dec(ok, cyc, seen, x);
        check("stall_done", ok, 1'b1);
        model_step(25'hC00000, exp_acc);
        check("stall_accept", bus.dec_accept, exp_acc);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_dec_valid", bus.dec_valid, 1'b1);
            check("stall_dec_accept", bus.dec_accept, exp_acc);
            check("stall_dec_fast", bus.dec_fast, 1'b0);
            check("stall_req_ready", bus.req_ready, 1'b0);
        end
        finish_dec();
        check("stall_release_valid", bus.dec_valid, 1'b0);
        check("stall_release_ready", bus.req_ready, 1'b1);
        $display("stall accept=%0b", exp_acc);

        // Reset while waiting on negexp.
        stub_e = 32'h3F800000;
        start_req(32'h3F800000, 32'hBF800000, "midrst");
        n = 0;
        while (dut.state_q != WAIT_HI && n < 50) begin
            tick();
            n++;
        end
        check("midrst_reached", dut.state_q == WAIT_HI, 1'b1);
        rst_n = 1'b0;
        tick();
        check("midrst_state", dut.state_q == IDLE, 1'b1);
        check("midrst_req_ready", bus.req_ready, 1'b1);
        check("midrst_dec_valid", bus.dec_valid, 1'b0);
        check("midrst_nx_inp_valid", bus.nx_inp_valid, 1'b0);
        check("midrst_nx_inp", bus.nx_inp, 32'h0);
        check("midrst_lfsr", dut.rnd, 24'hACE1);
        rst_n = 1'b1;
        lfsr_m = 24'hACE1;
        n = 0;
        while (stub_phase != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        v = '{32'h40000000, 32'hBF800000, 32'h3E000000, 32'hC0000000, 1'b0, 25'h200000};
        run_vec(v, "postrst");
        $display("post-reset request nx_inp check done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sa_accept.md
# sa_accept

Metropolis acceptance controller for the simulated-annealing TSP core, and the requesting side of `negexp`. It takes a candidate move's cost delta and the current −1/T and forms x = delta·(−1/T) with `floating_point_mult`. It then drives x into `negexp`, collects e^x, and returns an accept/reject decision by comparing e^x against a 24-bit LFSR uniform variate. The tour-mutation engine sits upstream; the swap commit logic sits downstream.

## Interface
Parameters:
- `SEED`, 24'hACE1, LFSR reset value; must be nonzero.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_delta` in 32: cost delta, IEEE single.
- `req_neg_inv_temp` in 32: −1/T, IEEE single; sampled with `req_delta`.
- `nx_inp` out 32: argument to `negexp`.
- `nx_inp_valid` out 1: launch strobe to `negexp`.
- `nx_out` in 32: `negexp` result.
- `nx_out_valid` in 1: `negexp` idle/result flag. It is high whenever `negexp` is idle, including one stale cycle after launch.
- `dec_valid` out 1: decision present.
- `dec_ready` in 1: downstream accepts decision.
- `dec_accept` out 1: 1 means accept the move.
- `dec_fast` out 1: 1 means decided without computing an exponential.

## Operation
- Request handshake: a request is taken when `req_valid & req_ready`. `req_delta` and `req_neg_inv_temp` are registered on that cycle.
- Fast path: if delta ≤ 0 (sign bit = 1, or bits[30:0] = 0), go to RESP with accept=1 and fast=1. The LFSR does not advance.
- States and transitions:
  - IDLE → MUL on a request that does not take the fast path. MUL pulses the multiplier tvalid once, then waits for `m_axis_result_tvalid` and latches x.
  - MUL → LAUNCH. LAUNCH holds `nx_inp_valid`=1 with `nx_inp`=x until a cycle where `nx_out_valid`=1; that is the cycle `negexp` accepts the launch.
  - LAUNCH → WAIT_LO. WAIT_LO waits for `nx_out_valid`=0, which discards the stale idle flag.
  - WAIT_LO → WAIT_HI. WAIT_HI waits for the first cycle with `nx_out_valid`=1, latches `nx_out` as e, and advances the LFSR once.
  - WAIT_HI → DECIDE → RESP → IDLE on `dec_ready`.
- Conversion of e to 25-bit Q0.24 `efix`, with S/E/M the float fields:
  - S=1 → 0.
  - E ≥ 127, including Inf/NaN → 0x1000000.
  - 103 ≤ E ≤ 126 → {1,M} >> (126−E).
  - E < 103 → 0.
- Decision: accept iff `rnd` < `efix`, where `rnd` is the 24-bit LFSR state. With `efix` = 0x1000000 the move is always accepted; with 0 it is always rejected.
- LFSR: 24-bit Galois, polynomial x^24+x^23+x^22+x^17+1. It steps only in WAIT_HI on the capture cycle.
- RESP: `dec_valid`=1. `dec_accept` and `dec_fast` are held stable until `dec_ready`.

## Timing
- Reset values:
  - state = IDLE, `req_ready`=1, `nx_inp_valid`=0, `nx_inp`=0.
  - `dec_valid`=0, `dec_accept`=0, `dec_fast`=0, LFSR = `SEED`.
- Fast path: request accepted in cycle 0, `dec_valid` in cycle 1.
- Slow path latency: 1 + Lmul + 1 (LAUNCH, longer if `negexp` is busy) + `negexp` latency + 1 (DECIDE) + 1 cycles to `dec_valid`.
- Back-to-back: the next request can be taken on the cycle after the `dec_valid & dec_ready` handshake.
- Mid-operation reset: `rst_n` low in any state returns immediately to IDLE with all outputs at reset values.
  - `negexp` may still be running; the LAUNCH wait-for-idle rule absorbs this.
  - A `nx_out_valid` rise while in IDLE or MUL is ignored.
- Both `nx_out_valid`=1 and `dec_ready` are registered-sampled; there are no combinational paths from inputs to `nx_inp_valid`.

## Structure
- Shared package `sa_pkg`:
  - `FP_ONE` = 32'h3f800000.
  - `LFSR_TAPS` = 24'hE10000.
  - The `sa_accept_state_t` enum (IDLE, MUL, LAUNCH, WAIT_LO, WAIT_HI, DECIDE, RESP).
  - Float field-extract helpers (sign, exponent, mantissa).
- Sub-module `sa_lfsr24` (ports: `clk`, `rst_n`, `step`, `state[23:0]`, parameter `SEED`).
- `floating_point_mult` is instantiated inside.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → `req_ready`=1, `dec_valid`=0, `nx_inp_valid`=0, LFSR = 24'hACE1.
- Fast path: `req_delta`=32'hC0000000 (−2.0), then 32'h00000000, then 32'h80000000 → each gives `dec_valid` in cycle 1 with accept=1 and fast=1. `nx_inp_valid` never asserts and the LFSR is unchanged.
- Threshold, using a behavioural `negexp` stub returning 32'h3F000000 (`efix` = 0x800000):
  - force `rnd` = 0x7FFFFF → accept=1, fast=0.
  - force `rnd` = 0x800000 → accept=0.
- Conversion corners:
  - e = 32'h3F800000 → accept.
  - e = 32'hBE000000 → reject.
  - e = 32'h33000000 (2^−25) → reject.
  - e = 32'h7F800000 → accept.
- Handshakes:
  - stub busy (`nx_out_valid`=0) for 4 cycles at LAUNCH → `nx_inp_valid` held with stable `nx_inp` until idle.
  - `dec_ready`=0 for 5 cycles → `dec_valid`/`dec_accept` stable and `req_ready`=0.
- Reset asserted in WAIT_HI → IDLE next edge, outputs at reset values. A subsequent delta = 32'h40000000 with −1/T = 32'hBF800000 drives `nx_inp` = 32'hC0000000.
